// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma rotor-position controller.
package enigma_pkg;

  localparam int ALPHA_SIZE  = 26;
  localparam int NOTCH_M_DEF = 4;   // rotor II turnover at 'E'
  localparam int NOTCH_R_DEF = 21;  // rotor III turnover at 'V'

  typedef logic [7:0] letter_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    OUT  = 2'd2
  } stepper_state_e;

endpackage

// File: rtl/rotor_counter.sv
// One rotor position: register, shared 8-bit incrementer, wrap at ALPHA,
// notch compare and out-of-range detection on the load value.

// Team 8-bit incrementer.
module inc8 (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  assign y_o = a_i + 8'd1;
endmodule

module rotor_counter
  import enigma_pkg::*;
#(
  parameter int ALPHA = ALPHA_SIZE,
  parameter int NOTCH = 0
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    load_i,
  input  letter_t load_val_i,
  input  logic    step_en_i,
  output letter_t pos_o,
  output logic    notch_o,
  output logic    oor_o
);

  localparam letter_t ALPHA_L = letter_t'(ALPHA);
  localparam letter_t NOTCH_L = letter_t'(NOTCH);

  letter_t pos_q;
  letter_t pos_d;
  letter_t inc;
  letter_t wrapped;

  inc8 u_inc (
    .a_i(pos_q),
    .y_o(inc)
  );

  // pos_q never exceeds ALPHA-1, so the incremented value tops out at ALPHA.
  assign wrapped = (inc == ALPHA_L) ? '0 : inc;
  assign oor_o   = (load_val_i >= ALPHA_L);
  assign notch_o = (pos_q == NOTCH_L);
  assign pos_o   = pos_q;

  // Next position: load has priority over stepping; bad load values become 0.
  always_comb begin
    pos_d = pos_q;
    if (load_i) begin
      pos_d = oor_o ? '0 : load_val_i;
    end else if (step_en_i) begin
      pos_d = wrapped;
    end
  end

  // Position register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

endmodule

// File: rtl/rotor_stepper.sv
// Three-rotor Enigma stepping controller with valid/ready handshakes on the
// keypress input and the position output. Implements the middle-rotor
// double step.
module rotor_stepper
  import enigma_pkg::*;
#(
  parameter int ALPHA   = ALPHA_SIZE,
  parameter int NOTCH_M = NOTCH_M_DEF,
  parameter int NOTCH_R = NOTCH_R_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_pos_l,
  input  logic [7:0] load_pos_m,
  input  logic [7:0] load_pos_r,
  input  logic       step_valid,
  output logic       step_ready,
  output logic       pos_valid,
  input  logic       pos_ready,
  output logic [7:0] pos_l,
  output logic [7:0] pos_m,
  output logic [7:0] pos_r,
  output logic       err
);

  stepper_state_e state_q;
  stepper_state_e state_d;
  logic           err_q;
  logic           err_d;

  logic load_en;
  logic stepping;
  logic en_l, en_m, en_r;
  logic notch_m, notch_r, notch_l_unused;
  logic oor_l, oor_m, oor_r;

  // Loads are only honoured while idle; the step is applied during STEP.
  assign load_en  = load && (state_q == IDLE);
  assign stepping = (state_q == STEP);

  // Right always steps; middle steps on right notch or its own notch
  // (double step); left steps when the middle sits on its notch.
  assign en_r = stepping;
  assign en_m = stepping && (notch_r || notch_m);
  assign en_l = stepping && notch_m;

  rotor_counter #(.ALPHA(ALPHA), .NOTCH(0)) u_left (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load_en),
    .load_val_i(load_pos_l),
    .step_en_i (en_l),
    .pos_o     (pos_l),
    .notch_o   (notch_l_unused),
    .oor_o     (oor_l)
  );

  rotor_counter #(.ALPHA(ALPHA), .NOTCH(NOTCH_M)) u_middle (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load_en),
    .load_val_i(load_pos_m),
    .step_en_i (en_m),
    .pos_o     (pos_m),
    .notch_o   (notch_m),
    .oor_o     (oor_m)
  );

  rotor_counter #(.ALPHA(ALPHA), .NOTCH(NOTCH_R)) u_right (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load_en),
    .load_val_i(load_pos_r),
    .step_en_i (en_r),
    .pos_o     (pos_r),
    .notch_o   (notch_r),
    .oor_o     (oor_r)
  );

  // Sticky error: any out-of-range field in an honoured load.
  assign err_d = err_q | (load_en & (oor_l | oor_m | oor_r));
  assign err   = err_q;

  // State and error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Next-state: accept a keypress, step for one cycle, hold until consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (step_valid && step_ready) state_d = STEP;
      STEP:    state_d = OUT;
      OUT:     if (pos_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs; a concurrent load blocks keypress acceptance.
  always_comb begin
    step_ready = (state_q == IDLE) && !load;
    pos_valid  = (state_q == OUT);
  end

endmodule

// File: doc/rotor_stepper.md
# rotor_stepper

Enigma rotor-position controller for a three-rotor machine (left, middle, right). On each accepted keypress it advances the rotor positions per Enigma stepping rules, including the middle-rotor double step. Every position update goes through the team's 8-bit incrementer, with a wrap modulo 26. It sits upstream of the substitution path: its registered positions feed the rotor scramblers, and the result is handed off with a valid/ready handshake.

## Interface
- `ALPHA` — default 26 — alphabet size; positions are 0..ALPHA-1.
- `NOTCH_M` — default 4 — middle-rotor turnover position (rotor II, 'E').
- `NOTCH_R` — default 21 — right-rotor turnover position (rotor III, 'V').

Ports:
- `clk` — in — 1 — single clock, rising edge.
- `rst_n` — in — 1 — asynchronous, active-low reset.
- `load` — in — 1 — load initial positions; honoured only in IDLE.
- `load_pos_l`, `load_pos_m`, `load_pos_r` — in — 8 each — initial positions.
- `step_valid` — in — 1 — keypress request.
- `step_ready` — out — 1 — block can accept a keypress.
- `pos_valid` — out — 1 — stepped positions available.
- `pos_ready` — in — 1 — downstream consumes the positions.
- `pos_l`, `pos_m`, `pos_r` — out — 8 each — current rotor positions, always driven from registers.
- `err` — out — 1 — sticky flag; set by an out-of-range load.

## Operation
- FSM states: IDLE, STEP, OUT.
  - IDLE → STEP when `step_valid && step_ready`.
  - STEP → OUT unconditionally.
  - OUT → IDLE when `pos_ready`.
- `step_ready` = (state == IDLE) && !`load`. When `load` and `step_valid` are both high in IDLE, load wins and the step is not accepted.
- Load, in IDLE only:
  - Each field < ALPHA is registered as given.
  - Any field ≥ ALPHA sets `err` and that field is registered as 0.
  - `load` in STEP or OUT is ignored.
  - A load does not raise `pos_valid`.
- Step, computed in STEP from pre-step positions:
  - Right rotor always steps.
  - Middle rotor steps if `pos_r == NOTCH_R` or `pos_m == NOTCH_M` (double step).
  - Left rotor steps if `pos_m == NOTCH_M`.
- Arithmetic: next = incrementer(pos); if next == ALPHA, the result is 0. Result width is 8 bits, and no value ≥ ALPHA is ever registered.
- `err` clears only on reset.

## Timing
- Reset values: all positions 0, `err` 0, `pos_valid` 0, `step_ready` 1, state IDLE.
- Handshake accepted at edge N. At edge N+1 the new positions are registered and state becomes OUT, so `pos_valid` is high in cycle N+1.
- `pos_valid` stays high, with positions stable, until `pos_ready`. The cycle after the transfer, `step_ready` is high again.
- Throughput: one keypress per 3 cycles with `pos_ready` tied high.
- Load takes effect at the next edge; the positions are visible the following cycle.
- Reset asserted in any state forces the reset values immediately. An in-flight step is discarded.

## Structure
- `enigma_pkg` holds:
  - `ALPHA_SIZE` = 26
  - letter type `logic [7:0]`
  - the `stepper_state_e` enum (IDLE, STEP, OUT)
  - default notch constants
- Sub-module `rotor_counter` is instantiated three times. Each instance contains:
  - the position register
  - one 8-bit incrementer instance
  - the wrap compare to ALPHA
  - a notch-compare output
  - `step_en`, load, and out-of-range detect
- The top level holds the FSM, the step-enable logic and the handshake.

## Test plan
- Reset, then idle → positions 0,0,0; `step_ready` 1; `pos_valid` 0; `err` 0.
- Load 0,3,20, then three keypresses with `pos_ready` high → 0,3,21 → 0,4,22 → 1,5,23 (double step on the third).
- Load 0,0,25 and step → 0,0,0. Load 25,4,10 and step → 0,5,11 (left wraps).
- Accept a step, hold `pos_ready` low for 4 cycles → `pos_valid` stays 1, positions stable, `step_ready` 0; release → IDLE next cycle.
- Load 30,2,26 → positions 0,2,0 and `err` 1; then `load` and `step_valid` in the same IDLE cycle → load taken, no step.
- Deassert `rst_n` during STEP after loading 5,5,5 → positions 0,0,0 immediately, `pos_valid` 0, state IDLE.
